// File: rtl/vpopc_seq.sv
// vpopc_seq -- command sequencer for the vector mask population-count unit.
//
// Accepts one vpopc.m command at a time, reads the source mask beats from the
// vector register file, trims the tail beat to vl, frames the beats into the
// popcount unit, waits for its result and hands the count to writeback.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_src_addr, cmd_dst_addr, cmd_vl, cmd_sew   command fields
//   rd_req, rd_addr, rd_data  register-file read port (data 1 cycle after req)
//   popc_valid/start/end, popc_m0, popc_sew, popc_addr   beat stream to unit
//   popc_out_valid, popc_out_vec                         unit result
//   res_valid / res_ready, res_data, res_addr            writeback handshake
//   res_err                   only with VPOPC_SEQ_TIMEOUT_EN: DRAIN timed out
//
// Build option: define VPOPC_SEQ_TIMEOUT_EN to add a 16-cycle DRAIN timeout
// and the res_err output.
module vpopc_seq #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned VL_WIDTH   = 16,
   parameter int unsigned SEW_WIDTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_src_addr,
   input  logic [ADDR_WIDTH-1:0]   cmd_dst_addr,
   input  logic [VL_WIDTH-1:0]     cmd_vl,
   input  logic [SEW_WIDTH-1:0]    cmd_sew,
   output logic                    rd_req,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH/8-1:0] rd_data,
   output logic                    popc_valid,
   output logic                    popc_start,
   output logic                    popc_end,
   output logic [DATA_WIDTH/8-1:0] popc_m0,
   output logic [SEW_WIDTH-1:0]    popc_sew,
   output logic [ADDR_WIDTH-1:0]   popc_addr,
   input  logic                    popc_out_valid,
   input  logic [DATA_WIDTH/8-1:0] popc_out_vec,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_WIDTH/8-1:0] res_data,
   output logic [ADDR_WIDTH-1:0]   res_addr
`ifdef VPOPC_SEQ_TIMEOUT_EN
   ,
   output logic                    res_err
`endif
);

   localparam int unsigned MW     = DATA_WIDTH / 8;
   localparam int unsigned LOG_MW = $clog2(MW);
   localparam logic [VL_WIDTH:0]   ONE_X = 1;
   localparam logic [VL_WIDTH-1:0] ONE   = 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      RESP
   } state_t;

   state_t state;

   // Command-latched beat bookkeeping.
   logic [VL_WIDTH-1:0] n_beats_q;
   logic [VL_WIDTH-1:0] issue_cnt;
   logic [MW-1:0]       tail_q;

   // Framing of the read issued this cycle; becomes beat framing next cycle.
   logic                rd_first;
   logic                rd_last;
   logic [MW-1:0]       trim_q;

`ifdef VPOPC_SEQ_TIMEOUT_EN
   logic [3:0]          timer;
`endif

   // Accept-time decode of vl/sew into beat count and tail keep-mask.
   logic [VL_WIDTH:0]   epb;
   logic [VL_WIDTH:0]   beat_sum;
   logic [VL_WIDTH:0]   rem;
   logic [31:0]         rem_bits;
   logic [VL_WIDTH-1:0] n_beats_c;
   logic [MW-1:0]       tail_c;

   always_comb begin
      epb       = (VL_WIDTH+1)'(MW) >> cmd_sew;
      beat_sum  = {1'b0, cmd_vl} + epb - ONE_X;
      n_beats_c = VL_WIDTH'(beat_sum >> (LOG_MW - 32'(cmd_sew)));
      rem       = {1'b0, cmd_vl} & (epb - ONE_X);
      rem_bits  = 32'(rem) << cmd_sew;
      tail_c    = '0;
      for (int unsigned b = 0; b < MW; b++) begin
         tail_c[b] = (rem == '0) || (b < rem_bits);
      end
   end

   assign cmd_ready = (state == IDLE) & ~rst;

   // Beat data is combinational from the read port; trim and strobe are
   // registered, so the mask is gated off whenever no beat is presented.
   assign popc_m0 = popc_valid ? (rd_data & trim_q) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n_beats_q  <= '0;
         issue_cnt  <= '0;
         tail_q     <= '0;
         rd_first   <= 1'b0;
         rd_last    <= 1'b0;
         trim_q     <= '0;
         rd_req     <= 1'b0;
         rd_addr    <= '0;
         popc_valid <= 1'b0;
         popc_start <= 1'b0;
         popc_end   <= 1'b0;
         popc_sew   <= '0;
         popc_addr  <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_addr   <= '0;
`ifdef VPOPC_SEQ_TIMEOUT_EN
         timer      <= '0;
         res_err    <= 1'b0;
`endif
      end else begin
         popc_valid <= rd_req;
         popc_start <= rd_req & rd_first;
         popc_end   <= rd_req & rd_last;
         trim_q     <= rd_last ? tail_q : '1;

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  popc_sew  <= cmd_sew;
                  popc_addr <= cmd_dst_addr;
                  if (cmd_vl == '0) begin
                     res_valid <= 1'b1;
                     res_data  <= '0;
                     res_addr  <= cmd_dst_addr;
                     state     <= RESP;
                  end else begin
                     n_beats_q <= n_beats_c;
                     tail_q    <= tail_c;
                     rd_req    <= 1'b1;
                     rd_addr   <= cmd_src_addr;
                     issue_cnt <= ONE;
                     rd_first  <= 1'b1;
                     rd_last   <= (n_beats_c == ONE);
                     state     <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               // issue_cnt counts requests already on the port.
               if (issue_cnt == n_beats_q) begin
                  rd_req   <= 1'b0;
                  rd_first <= 1'b0;
                  rd_last  <= 1'b0;
`ifdef VPOPC_SEQ_TIMEOUT_EN
                  timer    <= '0;
`endif
                  state    <= DRAIN;
               end else begin
                  rd_req    <= 1'b1;
                  rd_addr   <= rd_addr + 1'b1;
                  issue_cnt <= issue_cnt + ONE;
                  rd_first  <= 1'b0;
                  rd_last   <= (issue_cnt == n_beats_q - ONE);
               end
            end

            DRAIN: begin
               if (popc_out_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= popc_out_vec;
                  res_addr  <= popc_addr;
                  state     <= RESP;
               end
`ifdef VPOPC_SEQ_TIMEOUT_EN
               else if (timer == 4'd15) begin
                  res_valid <= 1'b1;
                  res_data  <= '0;
                  res_addr  <= popc_addr;
                  res_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  timer <= timer + 4'd1;
               end
`endif
            end

            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
`ifdef VPOPC_SEQ_TIMEOUT_EN
                  res_err   <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
